control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multi-cycle control unit for the Redux-V core; successor to the single-cycle combinational opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handshakes with instruction/data memory via req/ack, registers all control outputs, counts retired instructions, and flags a sticky fault on memory-ack timeout.
- Sits between the IR/PC datapath and the shared memory port.

Parameters:
- OPCODE_W, 4: opcode width; opcodes above 4'b1111 are illegal (fault).
- ALU_SEL_W, 4: sel_ula width.
- ACK_TIMEOUT, 15: max cycles mem_req is held without mem_ack before fault; 0 disables the timeout.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  IR opcode field, valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC for branch
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until ack
- mem_re  out  1  read request qualifier
- mem_we  out  1  write request qualifier
- i_or_d  out  1  0 = instruction address (PC), 1 = data address
- ir_we  out  1  IR load pulse
- pc_we  out  1  PC load pulse
- pc_inc  out  1  PC+1 pulse
- rf_we  out  1  register-file write pulse
- sel_ula  out  ALU_SEL_W  ALU operation
- b_mx, j_mx, r_mx, se_mx, d_mx, u_imm  out  1 each  datapath mux selects, held from DECODE to end of instruction
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- fault  out  1  sticky; set on timeout or illegal opcode

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all outputs 0; instr_count=0; fault=0; timeout counter=0. Reset mid-request drops mem_req immediately.
- All outputs registered; updated on rising clk.
- FETCH:
  - mem_req=1, mem_re=1, i_or_d=0.
  - On mem_ack: one-cycle ir_we=1 and pc_inc=1, then go to DECODE.
- DECODE (1 cycle): control word from opcode latched into the mux/sel_ula registers.
- Opcode map, fixed:
  - 0000 BRZR: b_mx=1, r_mx=0.
  - 0001 JI: j_mx=1, u_imm=1.
  - 0010 LD: d_mx=0.
  - 0011 ST.
  - 0100/0101 ALU-immediate: r_mx=1, se_mx=1, d_mx=1, sel 0100/0101, u_imm=0/1.
  - 0110/0111: sel 1000/1001.
  - 1000-1111: sel 0000-0111.
  - All ALU ops have d_mx=1.
  - Fields not listed are 0.
- EXEC (1 cycle):
  - ALU: rf_we pulse, retire.
  - BRZR: pc_we=zero, retire.
  - JI: pc_we=1, retire.
  - LD/ST: go to MEM.
- MEM:
  - mem_req=1, i_or_d=1; mem_re=1 for LD, mem_we=1 for ST.
  - On ack: LD goes to WB; ST retires.
- WB (1 cycle): rf_we pulse, retire.
- Retire: instr_count+1 in the same cycle the final pulse is issued; next state FETCH.
- Latency with ack in the first request cycle:
  - ALU/branch/jump: 3 cycles (FETCH, DECODE, EXEC).
  - ST: 4 cycles.
  - LD: 5 cycles.
  - Each cycle without ack adds 1 cycle.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each request cycle without ack.
  - When it reaches ACK_TIMEOUT with no ack, go to FAULT.
  - mem_ack in the same cycle the count reaches ACK_TIMEOUT counts as success.
- FAULT: all strobes and requests 0, fault=1; held until reset.
- mem_ack outside FETCH/MEM is ignored.
- instr_count wraps from all-ones to 0 with no flag.

Decomposition:
- Package redux_ctrl_pkg: opcode constants (OP_BRZR..OP_ALU7), state enum (FETCH, DECODE, EXEC, MEM, WB, FAULT), sel_ula codes, control-word struct.
- Sub-module control_decode: purely combinational opcode-to-control-word, instantiated once and registered in DECODE.

Test Plan:
- Reset: rst_n=0 asserted mid-MEM → mem_req=0 and state FETCH immediately; after release all outputs 0 and instr_count=0.
- ALU op 1010 with ack in the first cycle → ir_we at cycle 1; sel_ula=0010, d_mx=1 from DECODE; rf_we at cycle 3; instr_count=1.
- BRZR with zero=0, then zero=1 → pc_we=0 in the first case, 1 in the second; each retires in 3 cycles.
- LD with data ack delayed 3 cycles → mem_req, mem_re, i_or_d=1 held for 4 cycles, then rf_we pulse in WB; total 8 cycles.
- ST with ACK_TIMEOUT=4 and ack never asserted → fault=1 after 4 request cycles; no further strobes until reset.
- CNT_W=2: retire 5 instructions → instr_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/redux_ctrl_pkg.sv
// Shared types and constants for the Redux-V multi-cycle control unit.
// Opcode map, ALU select codes, FSM states and the decoded control word.
package redux_ctrl_pkg;

    localparam int SEL_W = 4;

    localparam logic [3:0] OP_BRZR  = 4'b0000;
    localparam logic [3:0] OP_JI    = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_ALUI0 = 4'b0100;
    localparam logic [3:0] OP_ALUI1 = 4'b0101;
    localparam logic [3:0] OP_ALUX0 = 4'b0110;
    localparam logic [3:0] OP_ALUX1 = 4'b0111;
    localparam logic [3:0] OP_ALU0  = 4'b1000;

    localparam logic [SEL_W-1:0] SEL_NONE = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_I0   = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_I1   = 4'b0101;
    localparam logic [SEL_W-1:0] SEL_X0   = 4'b1000;
    localparam logic [SEL_W-1:0] SEL_X1   = 4'b1001;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        FAULT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_BRZR,
        CL_JI,
        CL_LD,
        CL_ST
    } cls_t;

    typedef struct packed {
        cls_t             cls;
        logic             illegal;
        logic             b_mx;
        logic             j_mx;
        logic             r_mx;
        logic             se_mx;
        logic             d_mx;
        logic             u_imm;
        logic [SEL_W-1:0] sel;
    } ctrl_word_t;

endpackage

// File: rtl/control_fsm_if.sv
// Shared memory-port handshake between the control unit and memory.
// The controller drives the request side, memory answers with mem_ack.
interface control_fsm_if;

    logic mem_req;
    logic mem_re;
    logic mem_we;
    logic i_or_d;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_re,
        output mem_we,
        output i_or_d,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_re,
        input  mem_we,
        input  i_or_d,
        output mem_ack
    );

endinterface

// File: rtl/control_decode.sv
// Combinational opcode to control-word decoder for the Redux-V core.
// The FSM registers its output once per instruction, in DECODE.
module control_decode
    import redux_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_word_t          o_cw
);

    logic [3:0] w_op;
    logic       w_illegal;

    assign w_op = i_opcode[3:0];

    // Only a widened opcode field can encode values beyond the 16-entry map
    generate
        if (OPCODE_W > 4) begin : g_wide
            assign w_illegal = |i_opcode[OPCODE_W-1:4];
        end else begin : g_narrow
            assign w_illegal = 1'b0;
        end
    endgenerate

    always_comb begin
        o_cw         = '0;
        o_cw.cls     = CL_ALU;
        o_cw.sel     = SEL_NONE;
        o_cw.illegal = w_illegal;
        unique case (1'b1)
            (w_op == OP_BRZR): begin
                o_cw.cls  = CL_BRZR;
                o_cw.b_mx = 1'b1;
            end
            (w_op == OP_JI): begin
                o_cw.cls   = CL_JI;
                o_cw.j_mx  = 1'b1;
                o_cw.u_imm = 1'b1;
            end
            (w_op == OP_LD): begin
                o_cw.cls = CL_LD;
            end
            (w_op == OP_ST): begin
                o_cw.cls = CL_ST;
            end
            (w_op == OP_ALUI0),
            (w_op == OP_ALUI1): begin
                o_cw.r_mx  = 1'b1;
                o_cw.se_mx = 1'b1;
                o_cw.d_mx  = 1'b1;
                o_cw.u_imm = (w_op == OP_ALUI1);
                o_cw.sel   = (w_op == OP_ALUI1) ? SEL_I1 : SEL_I0;
            end
            (w_op == OP_ALUX0): begin
                o_cw.d_mx = 1'b1;
                o_cw.sel  = SEL_X0;
            end
            (w_op == OP_ALUX1): begin
                o_cw.d_mx = 1'b1;
                o_cw.sel  = SEL_X1;
            end
            (w_op >= OP_ALU0): begin
                o_cw.d_mx = 1'b1;
                o_cw.sel  = {1'b0, w_op[2:0]};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM for Redux-V: fetch/decode/exec/mem/wb sequencing,
// memory req/ack handshake, retired-instruction counter and sticky fault.
module control_fsm
    import redux_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALU_SEL_W   = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    control_fsm_if.master        mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_inc,
    output logic                 rf_we,
    output logic [ALU_SEL_W-1:0] sel_ula,
    output logic                 b_mx,
    output logic                 j_mx,
    output logic                 r_mx,
    output logic                 se_mx,
    output logic                 d_mx,
    output logic                 u_imm,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 fault
);

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t           r_state;
    cls_t             r_cls;
    logic [TMO_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic             r_mem_req;
    logic             r_mem_re;
    logic             r_mem_we;
    logic             r_i_or_d;
    logic             r_ir_we;
    logic             r_pc_we;
    logic             r_pc_inc;
    logic             r_rf_we;
    logic             r_b_mx;
    logic             r_j_mx;
    logic             r_r_mx;
    logic             r_se_mx;
    logic             r_d_mx;
    logic             r_u_imm;
    logic             r_fault;

    ctrl_word_t w_cw;
    logic       w_req_st;
    logic       w_acked;
    logic       w_wait;
    logic       w_tmo_hit;
    logic       w_retire;
    logic       w_fault_go;

    control_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_opcode (opcode),
        .o_cw     (w_cw)
    );

    // Ack only counts while a request is actually on the port
    assign w_req_st  = (r_state == FETCH) || (r_state == MEM);
    assign w_acked   = w_req_st && r_mem_req && mem.mem_ack;
    assign w_wait    = w_req_st && r_mem_req && !mem.mem_ack;
    assign w_tmo_hit = (ACK_TIMEOUT != 0) && (r_tmo == TMO_LAST);

    assign w_retire =
        ((r_state == EXEC) &&
         ((r_cls == CL_ALU) || (r_cls == CL_BRZR) || (r_cls == CL_JI))) ||
        ((r_state == MEM) && w_acked && (r_cls == CL_ST)) ||
        (r_state == WB);

    assign w_fault_go =
        (w_wait && w_tmo_hit) ||
        ((r_state == DECODE) && w_cw.illegal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_cls     <= CL_ALU;
            r_tmo     <= '0;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_mem_req <= 1'b0;
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_i_or_d  <= 1'b0;
            r_ir_we   <= 1'b0;
            r_pc_we   <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_rf_we   <= 1'b0;
            r_b_mx    <= 1'b0;
            r_j_mx    <= 1'b0;
            r_r_mx    <= 1'b0;
            r_se_mx   <= 1'b0;
            r_d_mx    <= 1'b0;
            r_u_imm   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_ir_we  <= 1'b0;
            r_pc_we  <= 1'b0;
            r_pc_inc <= 1'b0;
            r_rf_we  <= 1'b0;
            if (w_wait) begin
                r_tmo <= r_tmo + 1'b1;
            end
            unique case (r_state)
                FETCH: begin
                    // First cycle out of reset only raises the request
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                        r_mem_re  <= 1'b1;
                        r_i_or_d  <= 1'b0;
                        r_tmo     <= '0;
                    end else if (w_acked) begin
                        r_mem_req <= 1'b0;
                        r_mem_re  <= 1'b0;
                        r_ir_we   <= 1'b1;
                        r_pc_inc  <= 1'b1;
                        r_state   <= DECODE;
                    end
                end
                DECODE: begin
                    r_cls   <= w_cw.cls;
                    r_sel   <= w_cw.sel;
                    r_b_mx  <= w_cw.b_mx;
                    r_j_mx  <= w_cw.j_mx;
                    r_r_mx  <= w_cw.r_mx;
                    r_se_mx <= w_cw.se_mx;
                    r_d_mx  <= w_cw.d_mx;
                    r_u_imm <= w_cw.u_imm;
                    r_state <= EXEC;
                end
                EXEC: begin
                    case (r_cls)
                        CL_ALU:  r_rf_we <= 1'b1;
                        CL_BRZR: r_pc_we <= zero;
                        CL_JI:   r_pc_we <= 1'b1;
                        CL_LD,
                        CL_ST: begin
                            r_mem_req <= 1'b1;
                            r_mem_re  <= (r_cls == CL_LD);
                            r_mem_we  <= (r_cls == CL_ST);
                            r_i_or_d  <= 1'b1;
                            r_tmo     <= '0;
                            r_state   <= MEM;
                        end
                        default: r_state <= FAULT;
                    endcase
                end
                MEM: begin
                    if (w_acked) begin
                        r_mem_req <= 1'b0;
                        r_mem_re  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_cls == CL_LD) begin
                            r_state <= WB;
                        end
                    end
                end
                WB: begin
                    r_rf_we <= 1'b1;
                end
                FAULT: begin
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
            // Retire overrides the per-state updates and rearms the fetch
            if (w_retire) begin
                r_cnt     <= r_cnt + 1'b1;
                r_state   <= FETCH;
                r_mem_req <= 1'b1;
                r_mem_re  <= 1'b1;
                r_mem_we  <= 1'b0;
                r_i_or_d  <= 1'b0;
                r_tmo     <= '0;
            end
            if (w_fault_go) begin
                r_state   <= FAULT;
                r_fault   <= 1'b1;
                r_mem_req <= 1'b0;
                r_mem_re  <= 1'b0;
                r_mem_we  <= 1'b0;
                r_i_or_d  <= 1'b0;
            end
        end
    end

    assign mem.mem_req = r_mem_req;
    assign mem.mem_re  = r_mem_re;
    assign mem.mem_we  = r_mem_we;
    assign mem.i_or_d  = r_i_or_d;

    assign ir_we       = r_ir_we;
    assign pc_we       = r_pc_we;
    assign pc_inc      = r_pc_inc;
    assign rf_we       = r_rf_we;
    assign sel_ula     = ALU_SEL_W'(r_sel);
    assign b_mx        = r_b_mx;
    assign j_mx        = r_j_mx;
    assign r_mx        = r_r_mx;
    assign se_mx       = r_se_mx;
    assign d_mx        = r_d_mx;
    assign u_imm       = r_u_imm;
    assign instr_count = r_cnt;
    assign fault       = r_fault;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm with ACK_TIMEOUT=4 and CNT_W=2 so the
// timeout and counter-wrap boundaries are reachable in a few cycles.
module tb_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero;
    logic       ir_we;
    logic       pc_we;
    logic       pc_inc;
    logic       rf_we;
    logic [3:0] sel_ula;
    logic       b_mx;
    logic       j_mx;
    logic       r_mx;
    logic       se_mx;
    logic       d_mx;
    logic       u_imm;
    logic [1:0] instr_count;
    logic       fault;

    int passed;
    int total;

    control_fsm_if m_if ();

    control_fsm #(
        .OPCODE_W    (4),
        .ALU_SEL_W   (4),
        .ACK_TIMEOUT (4),
        .CNT_W       (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem         (m_if),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_inc      (pc_inc),
        .rf_we       (rf_we),
        .sel_ula     (sel_ula),
        .b_mx        (b_mx),
        .j_mx        (j_mx),
        .r_mx        (r_mx),
        .se_mx       (se_mx),
        .d_mx        (d_mx),
        .u_imm       (u_imm),
        .instr_count (instr_count),
        .fault       (fault)
    );

    logic [6:0]  strobes;
    logic [5:0]  muxes;
    logic [20:0] all_out;

    assign strobes = {m_if.mem_req, m_if.mem_re, m_if.mem_we,
                      ir_we, pc_we, pc_inc, rf_we};
    assign muxes   = {b_mx, j_mx, r_mx, se_mx, d_mx, u_imm};
    assign all_out = {strobes, m_if.i_or_d, muxes, sel_ula,
                      instr_count, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (all_out !== 21'd0)
            $display("FAIL rst_hold: got %h want 0", all_out);
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (all_out !== 21'd0)
            $display("FAIL rst_release: got %h want 0", all_out);
        else passed++;
        tick();
        total++;
        if ({m_if.mem_req, m_if.mem_re, m_if.i_or_d} !== 3'b110)
            $display("FAIL rst_fetch: got %b want 110",
                     {m_if.mem_req, m_if.mem_re, m_if.i_or_d});
        else passed++;
    endtask

    task automatic test_alu();
        opcode = 4'b1010;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        total++;
        if ({ir_we, pc_inc, m_if.mem_req} !== 3'b110)
            $display("FAIL alu_ir_we: got %b want 110",
                     {ir_we, pc_inc, m_if.mem_req});
        else passed++;
        tick();
        total++;
        if ({sel_ula, muxes, ir_we, rf_we} !== {4'b0010, 6'b000010, 2'b00})
            $display("FAIL alu_decode: got %b want 0010000010 00",
                     {sel_ula, muxes, ir_we, rf_we});
        else passed++;
        tick();
        total++;
        if ({rf_we, instr_count, m_if.mem_req} !== 4'b1011)
            $display("FAIL alu_retire: got %b want 1011",
                     {rf_we, instr_count, m_if.mem_req});
        else passed++;
    endtask

    task automatic test_brzr();
        for (int k = 0; k < 2; k++) begin
            opcode = 4'b0000;
            zero = k[0];
            m_if.mem_ack = 1'b1;
            tick();
            m_if.mem_ack = 1'b0;
            tick();
            total++;
            if ({muxes, sel_ula} !== {6'b100000, 4'b0000})
                $display("FAIL brzr_decode%0d: got %b want 1000000000",
                         k, {muxes, sel_ula});
            else passed++;
            tick();
            total++;
            if ({pc_we, rf_we, m_if.mem_req, instr_count} !==
                {k[0], 2'b01, 2'(k + 2)})
                $display("FAIL brzr_retire%0d: got %b want %b", k,
                         {pc_we, rf_we, m_if.mem_req, instr_count},
                         {k[0], 2'b01, 2'(k + 2)});
            else passed++;
        end
        zero = 1'b0;
    endtask

    task automatic test_ji();
        opcode = 4'b0001;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        tick();
        total++;
        if (muxes !== 6'b010001)
            $display("FAIL ji_decode: got %b want 010001", muxes);
        else passed++;
        tick();
        total++;
        if ({pc_we, instr_count} !== 3'b100)
            $display("FAIL ji_wrap: got %b want 100", {pc_we, instr_count});
        else passed++;
    endtask

    task automatic test_ld_delay();
        opcode = 4'b0010;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        tick();
        total++;
        if ({muxes, m_if.mem_req} !== 7'b0000000)
            $display("FAIL ld_decode: got %b want 0000000",
                     {muxes, m_if.mem_req});
        else passed++;
        tick();
        for (int i = 1; i <= 4; i++) begin
            total++;
            if ({m_if.mem_req, m_if.mem_re, m_if.mem_we, m_if.i_or_d} !==
                4'b1101)
                $display("FAIL ld_mem%0d: got %b want 1101", i,
                         {m_if.mem_req, m_if.mem_re,
                          m_if.mem_we, m_if.i_or_d});
            else passed++;
            m_if.mem_ack = (i == 4);
            tick();
        end
        m_if.mem_ack = 1'b0;
        total++;
        if ({m_if.mem_req, rf_we, fault} !== 3'b000)
            $display("FAIL ld_wb: got %b want 000",
                     {m_if.mem_req, rf_we, fault});
        else passed++;
        tick();
        total++;
        if ({rf_we, instr_count, m_if.mem_req, m_if.i_or_d} !== 5'b10110)
            $display("FAIL ld_retire: got %b want 10110",
                     {rf_we, instr_count, m_if.mem_req, m_if.i_or_d});
        else passed++;
    endtask

    task automatic test_st();
        opcode = 4'b0011;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        tick();
        tick();
        total++;
        if ({m_if.mem_req, m_if.mem_re, m_if.mem_we, m_if.i_or_d} !== 4'b1011)
            $display("FAIL st_mem: got %b want 1011",
                     {m_if.mem_req, m_if.mem_re, m_if.mem_we, m_if.i_or_d});
        else passed++;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        total++;
        if ({instr_count, rf_we, m_if.mem_we, m_if.mem_req, m_if.i_or_d} !==
            6'b100010)
            $display("FAIL st_retire: got %b want 100010",
                     {instr_count, rf_we, m_if.mem_we,
                      m_if.mem_req, m_if.i_or_d});
        else passed++;
    endtask

    task automatic test_timeout();
        opcode = 4'b0011;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        tick();
        tick();
        for (int i = 1; i <= 4; i++) begin
            total++;
            if ({m_if.mem_req, m_if.mem_we, fault} !== 3'b110)
                $display("FAIL tmo_wait%0d: got %b want 110", i,
                         {m_if.mem_req, m_if.mem_we, fault});
            else passed++;
            tick();
        end
        total++;
        if ({m_if.mem_req, m_if.mem_we, fault, instr_count} !== 5'b00110)
            $display("FAIL tmo_fault: got %b want 00110",
                     {m_if.mem_req, m_if.mem_we, fault, instr_count});
        else passed++;
        m_if.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opcode = 4'(i * 5);
            tick();
            total++;
            if ({strobes, fault} !== 8'b0000_0001)
                $display("FAIL tmo_hold%0d: got %b want 00000001", i,
                         {strobes, fault});
            else passed++;
        end
        m_if.mem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({fault, instr_count} !== 3'b000)
            $display("FAIL tmo_reset: got %b want 000", {fault, instr_count});
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        opcode = 4'b0101;
        m_if.mem_ack = 1'b0;
        tick();
        total++;
        if ({m_if.mem_req, ir_we} !== 2'b10)
            $display("FAIL b2b_fetch_wait: got %b want 10",
                     {m_if.mem_req, ir_we});
        else passed++;
        m_if.mem_ack = 1'b1;
        tick();
        total++;
        if (ir_we !== 1'b1)
            $display("FAIL b2b_late_ack: got %b want 1", ir_we);
        else passed++;
        tick();
        total++;
        if ({sel_ula, muxes} !== {4'b0101, 6'b001111})
            $display("FAIL b2b_alui: got %b want 0101001111",
                     {sel_ula, muxes});
        else passed++;
        tick();
        total++;
        if ({rf_we, instr_count, m_if.mem_req, ir_we} !== 5'b10110)
            $display("FAIL b2b_retire1: got %b want 10110",
                     {rf_we, instr_count, m_if.mem_req, ir_we});
        else passed++;
        opcode = 4'b0110;
        tick();
        m_if.mem_ack = 1'b0;
        total++;
        if ({ir_we, pc_inc} !== 2'b11)
            $display("FAIL b2b_fetch2: got %b want 11", {ir_we, pc_inc});
        else passed++;
        tick();
        total++;
        if ({sel_ula, muxes} !== {4'b1000, 6'b000010})
            $display("FAIL b2b_alux: got %b want 1000000010",
                     {sel_ula, muxes});
        else passed++;
        tick();
        total++;
        if ({rf_we, instr_count} !== 3'b110)
            $display("FAIL b2b_retire2: got %b want 110",
                     {rf_we, instr_count});
        else passed++;
    endtask

    task automatic test_reset_mid_mem();
        opcode = 4'b0011;
        m_if.mem_ack = 1'b1;
        tick();
        m_if.mem_ack = 1'b0;
        tick();
        tick();
        total++;
        if (m_if.mem_req !== 1'b1)
            $display("FAIL mid_mem_req: got %b want 1", m_if.mem_req);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({strobes, m_if.i_or_d, instr_count} !== 10'd0)
            $display("FAIL mid_mem_drop: got %b want 0",
                     {strobes, m_if.i_or_d, instr_count});
        else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (all_out !== 21'd0)
            $display("FAIL mid_mem_release: got %h want 0", all_out);
        else passed++;
        tick();
        total++;
        if ({m_if.mem_req, m_if.mem_re, m_if.i_or_d} !== 3'b110)
            $display("FAIL mid_mem_fetch: got %b want 110",
                     {m_if.mem_req, m_if.mem_re, m_if.i_or_d});
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst_n = 1'b0;
        opcode = 4'b0000;
        zero = 1'b0;
        m_if.mem_ack = 1'b0;
        test_reset();
        test_alu();
        test_brzr();
        test_ji();
        test_ld_delay();
        test_st();
        test_timeout();
        test_back_to_back();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
